// File: rtl/snn_pkg.sv
// Shared types and constants for the neuron sweep scheduler.
// State encoding, external request codes and address-width helper.
package snn_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SWEEP,
    ST_DRAIN,
    ST_EXT,
    ST_DONE
  } sched_state_t;

  localparam logic [1:0] EXT_RD = 2'b01;
  localparam logic [1:0] EXT_WR = 2'b10;

  localparam int NEURON_NO_DEF = 256;
  localparam int AW_DEF = $clog2(NEURON_NO_DEF);

  function automatic logic ext_valid(
    input logic [1:0] req
  );
    return (req == EXT_RD) || (req == EXT_WR);
  endfunction

endpackage

// File: rtl/sweep_scheduler_if.sv
// External request and neuron-memory port bundle of the sweep scheduler.
// master = scheduler side, slave = requester/memory side.
interface sweep_scheduler_if #(
  parameter int AW = snn_pkg::AW_DEF
);
  logic [1:0]    ext_req;
  logic [AW-1:0] ext_rd_addr;
  logic [AW-1:0] ext_wr_addr;
  logic          ext_ack;
  logic          nm_rd_en;
  logic [AW-1:0] nm_rd_addr;
  logic          nm_wr_en;
  logic [AW-1:0] nm_wr_addr;
  logic          nm_src_ext;

  modport master (
    input  ext_req, ext_rd_addr, ext_wr_addr,
    output ext_ack,
    output nm_rd_en, nm_rd_addr,
    output nm_wr_en, nm_wr_addr,
    output nm_src_ext
  );

  modport slave (
    output ext_req, ext_rd_addr, ext_wr_addr,
    input  ext_ack,
    input  nm_rd_en, nm_rd_addr,
    input  nm_wr_en, nm_wr_addr,
    input  nm_src_ext
  );
endinterface

// File: rtl/sweep_scheduler_wb_delay_line.sv
// Writeback delay line: valid+address shift register of fixed depth.
// Entries keep shifting regardless of issue stalls.
module wb_delay_line #(
  parameter int DEPTH = 3,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_vld,
  input  logic [W-1:0] in_addr,
  output logic         out_vld,
  output logic [W-1:0] out_addr,
  output logic         empty
);

  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [DEPTH-1:0][W-1:0] addr_q, addr_d;

  // advance every stage by one; invalid slots carry a zero address
  always_comb begin
    vld_d     = '0;
    addr_d    = '0;
    vld_d[0]  = in_vld;
    addr_d[0] = in_vld ? in_addr : '0;
    for (int i = 1; i < DEPTH; i++) begin
      vld_d[i]  = vld_q[i-1];
      addr_d[i] = addr_q[i-1];
    end
  end

  // stage registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q  <= '0;
      addr_q <= '0;
    end else begin
      vld_q  <= vld_d;
      addr_q <= addr_d;
    end
  end

  assign out_vld  = vld_q[DEPTH-1];
  assign out_addr = addr_q[DEPTH-1];
  assign empty    = ~|vld_q;

endmodule

// File: rtl/sweep_scheduler.sv
// Neuron-memory port owner: per-tick address sweep plus external access.
// EXT_PREEMPT_EN: external requests preempt a running sweep.
module sweep_scheduler
  import snn_pkg::*;
#(
  parameter int NEURON_NO = 256,
  parameter int TD_WIDTH  = 16,
  parameter int UPD_LAT   = 3,
  parameter int TICK_CYC  = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sys_en,
  input  logic                fifo_afull,
  sweep_scheduler_if.master   bus,
  output logic [TD_WIDTH-1:0] ts,
  output logic                sweep_busy,
  output logic                step_done,
  output logic                overrun
);

  localparam int AW = $clog2(NEURON_NO);
  localparam int PW = $clog2(TICK_CYC);
  localparam logic [AW-1:0] LAST = AW'(NEURON_NO - 1);
  localparam logic [PW-1:0] PMAX = PW'(TICK_CYC - 1);

`ifdef EXT_PREEMPT_EN
  localparam bit PREEMPT = 1'b1;
`else
  localparam bit PREEMPT = 1'b0;
`endif

  sched_state_t        state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [PW-1:0]       presc_q, presc_d;
  logic [TD_WIDTH-1:0] ts_q, ts_d;
  logic                pend_q, pend_d;
  logic                ovr_q, ovr_d;
  logic                pre_q, pre_d;

  logic          ext_vld, issue, consume, tick;
  logic          ext_rd, ext_wr;
  logic          wb_vld, wb_empty;
  logic [AW-1:0] wb_addr;

  assign ext_vld = ext_valid(bus.ext_req);

  // tick prescaler, pending tick and sticky overrun
  always_comb begin
    tick    = sys_en && (presc_q == PMAX);
    presc_d = '0;
    if (sys_en && !tick) presc_d = presc_q + 1'b1;
    pend_d = (pend_q && !consume) || tick;
    ovr_d  = ovr_q || (tick && pend_q && !consume);
  end

  // scheduler next state and sweep issue
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ts_d    = ts_q;
    pre_d   = pre_q;
    issue   = 1'b0;
    consume = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ext_vld) begin
          state_d = ST_EXT;
        end else if (pend_q) begin
          state_d = ST_SWEEP;
          consume = 1'b1;
          cnt_d   = '0;
          ts_d    = ts_q + 1'b1;
        end
      end
      ST_SWEEP: begin
        if (PREEMPT && ext_vld) begin
          state_d = ST_DRAIN;
          pre_d   = 1'b1;
        end else if (!fifo_afull) begin
          issue = 1'b1;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (wb_empty) state_d = pre_q ? ST_EXT : ST_DONE;
      end
      ST_EXT: begin
        state_d = pre_q ? ST_SWEEP : ST_IDLE;
        pre_d   = 1'b0;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // state and counter registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      presc_q <= '0;
      ts_q    <= '0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
      pre_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      presc_q <= presc_d;
      ts_q    <= ts_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
      pre_q   <= pre_d;
    end
  end

  wb_delay_line #(
    .DEPTH (UPD_LAT),
    .W     (AW)
  ) u_wb (
    .clk      (clk),
    .reset    (reset),
    .in_vld   (issue),
    .in_addr  (cnt_q),
    .out_vld  (wb_vld),
    .out_addr (wb_addr),
    .empty    (wb_empty)
  );

  // memory port mux between sweep and external path
  always_comb begin
    bus.ext_ack    = (state_q == ST_EXT) && ext_vld;
    bus.nm_src_ext = (state_q == ST_EXT);
    ext_rd         = bus.ext_ack && (bus.ext_req == EXT_RD);
    ext_wr         = bus.ext_ack && (bus.ext_req == EXT_WR);
    bus.nm_rd_en   = issue || ext_rd;
    bus.nm_wr_en   = wb_vld || ext_wr;
    bus.nm_rd_addr = '0;
    bus.nm_wr_addr = '0;
    unique case (1'b1)
      issue:   bus.nm_rd_addr = cnt_q;
      ext_rd:  bus.nm_rd_addr = bus.ext_rd_addr;
      default: bus.nm_rd_addr = '0;
    endcase
    unique case (1'b1)
      wb_vld:  bus.nm_wr_addr = wb_addr;
      ext_wr:  bus.nm_wr_addr = bus.ext_wr_addr;
      default: bus.nm_wr_addr = '0;
    endcase
  end

  assign ts         = ts_q;
  assign overrun    = ovr_q;
  assign step_done  = (state_q == ST_DONE);
  assign sweep_busy = (state_q == ST_SWEEP) ||
                      (state_q == ST_DRAIN) ||
                      ((state_q == ST_EXT) && pre_q);

endmodule
